switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Synchronises and debounces the raw slide-switch inputs before they reach the switch PIO's input port. Each bit has a two-flop synchroniser and a stability counter. A bit's debounced output changes only after the synchronised input has held a new value for STABLE_CYCLES consecutive clocks. It sits between the board pins and the switch PIO `in_port`, so software reads clean, glitch-free levels.

## Interface
- WIDTH, 8, number of switch bits.
- STABLE_CYCLES, 50000, consecutive differing cycles required to accept a new level (1 ms at 50 MHz); legal range 2..2^CNT_W.
- CNT_W, 16, width of each per-bit stability counter.

- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- raw_in  input  WIDTH  asynchronous switch pins.
- out_port  output  WIDTH  debounced levels; drives the switch PIO `in_port`.
- changed  output  WIDTH  one-cycle pulse per bit when that out_port bit toggles (only with SWITCH_DEBOUNCE_CHANGE_EN).
- any_change  output  1  OR of `changed` (only with SWITCH_DEBOUNCE_CHANGE_EN).

## Operation
- **Synchroniser, per bit:** `s1 <= raw_in[i]`, then `s2 <= s1`. Only `s2` is used downstream.
- **Per-bit state:** counter `cnt` (CNT_W bits) and debounced register `q` (drives `out_port[i]`).
- **Each clock:**
  - If `s2 == q`: `cnt <= 0`.
  - Else if `cnt == STABLE_CYCLES-1`: `q <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Glitches:** any return of `s2` to `q` before acceptance clears `cnt`. Partial progress is never retained.
- **Counter range:** `cnt` never exceeds STABLE_CYCLES-1, so no wrap is possible. The counter needs no saturation logic.
- **Independence:** bits are fully independent. Simultaneous changes on several bits are each accepted on their own schedule.
- **Parameter check:** elaboration fails if STABLE_CYCLES < 2 or STABLE_CYCLES > 2^CNT_W.
- **Change detect (when compiled in):** `changed[i]` is high for exactly the cycle after `q` updates, i.e. registered `q ^ q_prev`.

## Timing
- **Reset values:** on reset_n low, asynchronously: `s1`, `s2`, `q`, `cnt` = 0; `out_port` = 0; `changed` = 0; `any_change` = 0.
- **After reset:** switches already high at reset appear on `out_port` after the normal debounce latency.
- **Latency:** if raw_in holds a new value from rising edge 1 (the edge that first captures it), `out_port` changes on edge STABLE_CYCLES+2. With change detect, `changed` pulses one edge later (edge STABLE_CYCLES+3).
- **Rejection:** a pulse on `s2` lasting ≤ STABLE_CYCLES-1 cycles never reaches `out_port`.
- **Reset mid-count:** reset aborts the count. After release, debouncing restarts from `q = 0`, `cnt = 0`.
- **Downstream registering:** `out_port` is a register output. The PIO adds its own registered read, so software sees at most one further cycle of latency.

## Configuration
- **Macro:** `SWITCH_DEBOUNCE_CHANGE_EN`.
- **Defined:** `changed`, `any_change` ports and the `q_prev` register exist, for use as an interrupt or edge source.
- **Undefined:** those ports and registers are absent. `out_port` behaviour is identical in both builds.

## Structure
- **Shared package `switch_debounce_pkg`:** default constants for WIDTH, STABLE_CYCLES and CNT_W, plus a function computing the minimum CNT_W from STABLE_CYCLES.
- **Sub-module `switch_debounce_bit`:** one synchroniser, counter and `q` register. The top generates WIDTH instances and optional change-detect logic.
- **Synchroniser attributes:** flops carry the synchroniser attribute for timing analysis.

## Test plan
Bench configuration: WIDTH=8, STABLE_CYCLES=4, CNT_W=3.
- Reset with raw_in=8'hFF held → out_port=8'h00 during reset; out_port=8'hFF on edge 6 after release (edge 1 = first capture); changed=8'hFF pulse on edge 7.
- out_port=0, raw_in[0] pulses high for 3 cycles → out_port stays 8'h00; changed never asserts.
- raw_in[0] toggles 1,0,1,1,1,1 (one cycle each, then held) → out_port[0] rises exactly 4 cycles after `s2` last becomes stable 1.
- raw_in 8'h00→8'hA5 in one cycle → out_port=8'hA5 on a single edge; any_change high for one cycle.
- reset_n pulsed low with cnt=2 on bit 3 → out_port=0 immediately, asynchronously; full 4-cycle requalification after release.
- Build without SWITCH_DEBOUNCE_CHANGE_EN → compiles without `changed`/`any_change`; out_port trace matches the previous run cycle-for-cycle.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared defaults and sizing helper for the slide-switch debouncer.
// Optional change detection is compiled in with SWITCH_DEBOUNCE_CHANGE_EN.
package switch_debounce_pkg;

  // Smallest counter width that can hold STABLE_CYCLES-1.
  function automatic int unsigned min_cnt_w(input int unsigned stable_cycles);
    return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
  endfunction

  localparam int unsigned WIDTH_DEF         = 8;
  localparam int unsigned STABLE_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF         = min_cnt_w(STABLE_CYCLES_DEF);

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and debounced level.
// A new level is accepted after STABLE_CYCLES consecutive differing samples.
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_q
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic r_s1;
  (* ASYNC_REG = "TRUE" *) logic r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
        r_q   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw slide-switch pins for the switch PIO in_port.
// Define SWITCH_DEBOUNCE_CHANGE_EN to add the changed / any_change edge outputs.
module switch_debouncer
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = WIDTH_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] out_port
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
  ,
  output logic [WIDTH-1:0] changed,
  output logic             any_change
`endif
);

  if ((STABLE_CYCLES < 2) || (64'(STABLE_CYCLES) > (64'(1) << CNT_W))) begin : g_param_err
    $error("switch_debouncer: STABLE_CYCLES must lie in 2..2**CNT_W");
  end

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .i_raw  (raw_in[i]),
      .o_q    (w_q[i])
    );
  end

  assign out_port = w_q;

`ifdef SWITCH_DEBOUNCE_CHANGE_EN
  logic [WIDTH-1:0] r_q_prev;
  logic [WIDTH-1:0] r_changed;
  logic             r_any_change;

  // Pulses land the cycle after out_port moves, so they never lead the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_prev     <= '0;
      r_changed    <= '0;
      r_any_change <= 1'b0;
    end else begin
      r_q_prev     <= w_q;
      r_changed    <= w_q ^ r_q_prev;
      r_any_change <= |(w_q ^ r_q_prev);
    end
  end

  assign changed    = r_changed;
  assign any_change = r_any_change;
`else
  // Level-only build: no edge-detect state.
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (WIDTH=8, STABLE_CYCLES=4, CNT_W=3).
// A window-based reference model predicts out_port (and changed) events.
module tb_switch_debouncer;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] raw_in;
  logic [7:0] out_port;
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
  logic [7:0] changed;
  logic       any_change;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  ev_t        exp_q[$];
  ev_t        chg_q[$];
  logic [7:0] raw_hist[$];
  logic [7:0] s2_hist[$];
  logic [7:0] m_out;
  logic [7:0] mon_prev;

  switch_debouncer #(
    .WIDTH        (8),
    .STABLE_CYCLES(N),
    .CNT_W        (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (raw_in),
    .out_port(out_port)
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
    ,
    .changed   (changed),
    .any_change(any_change)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a bit flips once the last N synchronised samples since
  // reset all disagree with its current level.
  always @(posedge clk or negedge reset_n) begin
    logic [7:0] s2;
    logic [7:0] mask;
    bit         ok;
    if (!reset_n) begin
      raw_hist.delete();
      s2_hist.delete();
      exp_q.delete();
      chg_q.delete();
      m_out = '0;
      if (clk) cyc++;
    end else begin
      cyc++;
      raw_hist.push_back(raw_in);
      s2 = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : 8'h00;
      s2_hist.push_back(s2);
      if (raw_hist.size() > 8) void'(raw_hist.pop_front());
      if (s2_hist.size() > N) void'(s2_hist.pop_front());
      mask = '0;
      if (s2_hist.size() == N) begin
        for (int b = 0; b < 8; b++) begin
          ok = 1'b1;
          for (int k = 0; k < N; k++)
            if (s2_hist[k][b] == m_out[b]) ok = 1'b0;
          mask[b] = ok;
        end
      end
      if (mask != 0) begin
        m_out ^= mask;
        exp_q.push_back('{cyc: cyc, val: m_out});
        chg_q.push_back('{cyc: cyc + 1, val: mask});
      end
    end
  end

  // Monitor: every observed out_port change must match the next predicted event.
  always @(posedge clk or negedge reset_n) begin
    ev_t e;
    if (!reset_n) begin
      mon_prev = '0;
    end else begin
      #1;
      if (out_port !== mon_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_evt: out_port moved to %0h at cycle %0d, required no change", out_port, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_evt_cycle", cyc, e.cyc);
          check("out_evt_value", {24'h0, out_port}, {24'h0, e.val});
        end
        mon_prev = out_port;
      end
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
      begin
        logic exp_any;
        exp_any = (chg_q.size() > 0) && (chg_q[0].cyc == cyc);
        check("any_change", {31'h0, any_change}, {31'h0, exp_any});
        if (exp_any) begin
          e = chg_q.pop_front();
          check("changed", {24'h0, changed}, {24'h0, e.val});
        end else begin
          check("changed_idle", {24'h0, changed}, 32'h0);
        end
      end
`endif
    end
  end

  task automatic drive(input logic [7:0] v, input int n);
    @(negedge clk);
    raw_in = v;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    reset_n = 1'b0;
    raw_in  = 8'hFF;

    // Switches high through reset: held at zero, then accepted on edge 6.
    repeat (3) begin
      @(negedge clk);
      check("reset_out", {24'h0, out_port}, 32'h0);
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
      check("reset_changed", {23'h0, any_change, changed}, 32'h0);
`endif
    end
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("post_reset_edge5", {24'h0, out_port}, 32'h0);
    @(posedge clk);
    #1 check("post_reset_edge6", {24'h0, out_port}, 32'hFF);
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
    @(posedge clk);
    #1 check("post_reset_changed7", {24'h0, changed}, 32'hFF);
`endif

    // Back to zero, then a 3-cycle glitch on bit 0 must be rejected.
    drive(8'h00, 10);
    drive(8'h01, 3);
    drive(8'h00, 10);
    check("glitch_reject", {24'h0, out_port}, 32'h0);

    // Bouncing edge on bit 0 before settling high.
    drive(8'h01, 1);
    drive(8'h00, 1);
    drive(8'h01, 10);
    check("bounce_settled", {24'h0, out_port}, 32'h01);
    drive(8'h00, 10);

    // Several bits at once land on a single edge.
    drive(8'hA5, 10);
    check("multi_bit", {24'h0, out_port}, 32'hA5);

    // Reset in the middle of bit 3 qualifying (cnt == 2).
    @(negedge clk);
    raw_in = 8'hAD;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", {24'h0, out_port}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("requal_edge5", {24'h0, out_port}, 32'h0);
    @(posedge clk);
    #1 check("requal_edge6", {24'h0, out_port}, 32'hAD);
    drive(8'hAD, 4);

    // Random bursts: a few bits flip, held for 1..7 cycles.
    v = 8'hAD;
    for (int s = 0; s < 80; s++) begin
      v = v ^ 8'($urandom() & $urandom());
      drive(v, $urandom_range(1, 7));
    end
    drive(v, 12);

    check("exp_q_drained", exp_q.size(), 0);
`ifdef SWITCH_DEBOUNCE_CHANGE_EN
    check("chg_q_drained", chg_q.size(), 0);
`endif
    check("final_level", {24'h0, out_port}, {24'h0, v});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
